// File: rtl/bcd_conv_seq_if.sv
// ============================================================================
// Module      : bcd_conv_seq_if
// Description : Handshake and result bundle for the sequential binary-to-BCD
//               converter. The optional blank[] vector exists only when
//               BCD_CONV_BLANK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_conv_seq_if #(
    parameter int W      = 13,
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
    logic                  busy;
`ifdef BCD_CONV_BLANK_EN
    logic [DIGITS-1:0]     blank;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, ovf, busy, blank
    );
    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, ovf, busy, blank
    );
`else
    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, ovf, busy
    );
    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, ovf, busy
    );
`endif
endinterface

`default_nettype wire

// File: rtl/bcd_conv_seq.sv
// ============================================================================
// Module      : bcd_conv_seq
// Description : Sequential binary-to-BCD converter (double dabble), one shift
//               per clock, valid/ready on both sides, overflow flag when the
//               value does not fit in DIGITS digits.
//               Optional leading-zero blanking vector: BCD_CONV_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_conv_seq #(
    parameter int W      = 13,
    parameter int DIGITS = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    bcd_conv_seq_if.slave    bus
);

    localparam int                 c_CNT_W = (W < 2) ? 1 : $clog2(W);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [W-1:0]           r_bin_sr;
    logic [4*DIGITS-1:0]    r_acc;
    logic                   r_ovf_acc;
    logic [4*DIGITS-1:0]    r_bcd;
    logic                   r_ovf;

    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   w_busy;
    logic                   w_accept;
    logic                   w_last;
    logic [4*DIGITS-1:0]    w_adj;
    logic [4*DIGITS-1:0]    w_acc_nxt;
    logic                   w_ovf_nxt;

    // Add-3 correction on every digit that is 5 or more before the shift
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign w_adj[4*k +: 4] = (r_acc[4*k +: 4] >= 4'd5) ? (r_acc[4*k +: 4] + 4'd3)
                                                            : r_acc[4*k +: 4];
    end

    // The binary MSB enters digit 0; the bit leaving the top digit is a carry
    // worth 10^DIGITS, so it is remembered as overflow and otherwise dropped.
    assign w_acc_nxt = {w_adj[4*DIGITS-2:0], r_bin_sr[W-1]};
    assign w_ovf_nxt = r_ovf_acc | w_adj[4*DIGITS-1];
    assign w_last    = (r_cnt == c_LAST);
    assign w_accept  = bus.in_valid & w_in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                // Taking the result frees the converter in the same cycle
                w_in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    w_next = bus.in_valid ? S_SHIFT : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Shift datapath and result capture on the final shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bin_sr  <= '0;
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_bin_sr  <= bus.bin;
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_cnt     <= r_cnt + c_CNT_W'(1);
            r_bin_sr  <= r_bin_sr << 1;
            r_acc     <= w_acc_nxt;
            r_ovf_acc <= w_ovf_nxt;
            if (w_last) begin
                r_bcd <= w_acc_nxt;
                r_ovf <= w_ovf_nxt;
            end
        end
    end

`ifdef BCD_CONV_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank;

    // Digit k blanks when it and every digit above it is zero; digit 0 never blanks
    always_comb begin
        logic v_zero;
        w_blank = '0;
        v_zero  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            v_zero     = v_zero & (w_acc_nxt[4*k +: 4] == 4'd0);
            w_blank[k] = v_zero;
        end
    end

    // Blank vector is captured together with the digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank <= '0;
        end else if ((r_state == S_SHIFT) && w_last && !w_accept) begin
            r_blank <= w_blank;
        end
    end

    assign bus.blank = r_blank;
`endif

    // In reset the converter must not advertise readiness
    assign bus.in_ready  = w_in_ready & rst_n;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.bcd       = r_bcd;
    assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire
